// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares the single L2 request port between two L1 caches: requester 0
// (L1 instruction) and requester 1 (L1 data). Grants are round-robin and
// each grant is held for one complete L2 transaction, from the request
// until the L2 ready pulse. Each transaction is a block fill (we=0) or a
// block writeback (we=1).
//
// Every transaction passes through one IDLE arbitration cycle. The
// requesters update their request on the edge after their ready pulse, so
// requests seen in the ready cycle are stale and are not re-arbitrated
// until the next IDLE cycle.
//
// Optional feature macro: ARB_STATS_EN
//   Defined   -> adds saturating counters stat_grant0, stat_grant1 and
//                stat_conflict (STAT_W bits each).
//   Undefined -> those ports, counters and the STAT_W parameter do not exist.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   rN_request          requester N level request, held until rN_ready
//   rN_we               requester N: 1 = writeback, 0 = fill
//   rN_addr             requester N block address
//   rN_din              requester N writeback block
//   rN_ready            requester N transaction done, 1-cycle pulse
//   rN_dout             requester N fill block (copy of l2_dout)
//   l2_request/we/addr/din   granted requester's request towards L2
//   l2_ready, l2_dout   L2 done pulse and fill block
//   stat_*              statistics counters (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
`ifdef ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_request,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_din,
    output logic              r0_ready,
    output logic [DATA_W-1:0] r0_dout,
    input  logic              r1_request,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_din,
    output logic              r1_ready,
    output logic [DATA_W-1:0] r1_dout,
    output logic              l2_request,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_din,
    input  logic              l2_ready,
    input  logic [DATA_W-1:0] l2_dout
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_reg, state_next;
    // Requester preferred on the next conflict.
    logic   ptr_reg, ptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        l2_request = 1'b0;
        l2_we      = 1'b0;
        l2_addr    = '0;
        l2_din     = '0;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                // l2_ready seen here is spurious and deliberately ignored.
                if (r0_request && r1_request) begin
                    state_next = ptr_reg ? GRANT1 : GRANT0;
                end else if (r0_request) begin
                    state_next = GRANT0;
                end else if (r1_request) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                // l2_request follows the live request even if the requester
                // misbehaves and drops it; the grant itself is held.
                l2_request = r0_request;
                l2_we      = r0_we;
                l2_addr    = r0_addr;
                l2_din     = r0_din;
                r0_ready   = l2_ready;
                if (l2_ready) begin
                    state_next = IDLE;
                    ptr_next   = 1'b1;
                end
            end
            GRANT1: begin
                l2_request = r1_request;
                l2_we      = r1_we;
                l2_addr    = r1_addr;
                l2_din     = r1_din;
                r1_ready   = l2_ready;
                if (l2_ready) begin
                    state_next = IDLE;
                    ptr_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fill data is broadcast; each requester only looks at it with its ready.
    assign r0_dout = l2_dout;
    assign r1_dout = l2_dout;

`ifdef ARB_STATS_EN
    // Index 0: grants to r0, 1: grants to r1, 2: IDLE cycles with a conflict.
    logic [2:0]        stat_inc;
    logic [STAT_W-1:0] stat_reg [3];

    assign stat_inc[0] = (state_reg == IDLE) && (state_next == GRANT0);
    assign stat_inc[1] = (state_reg == IDLE) && (state_next == GRANT1);
    assign stat_inc[2] = (state_reg == IDLE) && r0_request && r1_request;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                stat_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                // Saturate at all-ones instead of wrapping.
                if (stat_inc[i] && (stat_reg[i] != '1)) begin
                    stat_reg[i] <= stat_reg[i] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_grant0   = stat_reg[0];
    assign stat_grant1   = stat_reg[1];
    assign stat_conflict = stat_reg[2];
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_port_arbiter
//
// Directed scenarios for reset, single fill, conflict ordering, alternation,
// writeback pass-through and spurious L2 ready, followed by a randomized run
// checked cycle by cycle against a transaction-level ownership model.
// Build with +define+ARB_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_l2_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_request, r0_we, r0_ready;
    logic [5:0]  r0_addr;
    logic [31:0] r0_din, r0_dout;
    logic        r1_request, r1_we, r1_ready;
    logic [5:0]  r1_addr;
    logic [31:0] r1_din, r1_dout;
    logic        l2_request, l2_we, l2_ready;
    logic [5:0]  l2_addr;
    logic [31:0] l2_din, l2_dout;
`ifdef ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_request (r0_request),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_din     (r0_din),
        .r0_ready   (r0_ready),
        .r0_dout    (r0_dout),
        .r1_request (r1_request),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_din     (r1_din),
        .r1_ready   (r1_ready),
        .r1_dout    (r1_dout),
        .l2_request (l2_request),
        .l2_we      (l2_we),
        .l2_addr    (l2_addr),
        .l2_din     (l2_din),
        .l2_ready   (l2_ready),
        .l2_dout    (l2_dout)
`ifdef ARB_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    task automatic test_reset();
        rst_n   = 1'b0;
        l2_dout = 32'h5a5a1234;
        @(negedge clk); @(negedge clk); #1;
        check_cnt++;
        if ({l2_request, l2_we, l2_addr, l2_din, r0_ready, r1_ready} !== 41'd0) begin
            $display("FAIL reset_outputs: got %h want 0",
                     {l2_request, l2_we, l2_addr, l2_din, r0_ready, r1_ready});
        end else pass_cnt++;
        check_cnt++;
        if ({r0_dout, r1_dout} !== {2{32'h5a5a1234}}) begin
            $display("FAIL reset_dout: got %h want %h", {r0_dout, r1_dout}, {2{32'h5a5a1234}});
        end else pass_cnt++;
        // r0 transaction moves the pointer to 1, then r1 is granted alone.
        rst_n = 1'b1; r0_request = 1'b1; r0_addr = 6'h01; r1_addr = 6'h02;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if (r0_ready !== 1'b1) $display("FAIL reset_pre_grant0: got %b want 1", r0_ready);
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r0_request = 1'b0; r1_request = 1'b1;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_request, r1_ready} !== 2'b11) $display("FAIL reset_pre_grant1: got %b want 11", {l2_request, r1_ready});
        else pass_cnt++;
        // Asynchronous reset in the middle of GRANT1.
        rst_n = 1'b0; #1;
        check_cnt++;
        if ({l2_request, r1_ready, l2_addr} !== 8'd0) begin
            $display("FAIL reset_mid_grant1: got %h want 0", {l2_request, r1_ready, l2_addr});
        end else pass_cnt++;
        @(negedge clk); rst_n = 1'b1; r1_request = 1'b0; l2_ready = 1'b0;
        // Pointer must be back at 0: r0 wins the conflict.
        @(negedge clk); r0_request = 1'b1; r1_request = 1'b1;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_request, l2_addr, r0_ready} !== {1'b1, 6'h01, 1'b1}) begin
            $display("FAIL reset_ptr0: got %h want %h", {l2_request, l2_addr, r0_ready}, {1'b1, 6'h01, 1'b1});
        end else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r0_request = 1'b0;
        @(negedge clk); l2_ready = 1'b1;
        @(negedge clk); l2_ready = 1'b0; r1_request = 1'b0;
    endtask

    task automatic test_single_fill();
        int hi = 0;
        r0_request = 1'b1; r0_we = 1'b0; r0_addr = 6'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            l2_ready = (i == 6);
            l2_dout  = (i == 6) ? 32'h03020100 : $urandom;
            if (i == 7) r0_request = 1'b0;
            #1;
            if (l2_request) hi++;
            if (i == 1) begin
                check_cnt++;
                if (l2_request !== 1'b1) $display("FAIL fill_latency: got %b want 1", l2_request);
                else pass_cnt++;
            end
            check_cnt++;
            if (r0_ready !== (i == 6)) $display("FAIL fill_ready_c%0d: got %b want %b", i, r0_ready, (i == 6));
            else pass_cnt++;
            if (i == 6) begin
                check_cnt++;
                if (r0_dout !== 32'h03020100) $display("FAIL fill_dout: got %h want 03020100", r0_dout);
                else pass_cnt++;
            end
        end
        l2_ready = 1'b0;
        check_cnt++;
        if (hi != 6) $display("FAIL fill_req_cycles: got %0d want 6", hi);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; r0_addr = 6'h11; r1_addr = 6'h22; r0_request = 1'b1; r1_request = 1'b1;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_addr, r0_ready, r1_ready} !== {6'h11, 2'b10}) begin
            $display("FAIL conflict_first: got %h want %h", {l2_addr, r0_ready, r1_ready}, {6'h11, 2'b10});
        end else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r0_request = 1'b0; #1;
        check_cnt++;
        if (l2_request !== 1'b0) $display("FAIL conflict_idle_gap: got %b want 0", l2_request);
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_addr, r0_ready, r1_ready} !== {6'h22, 2'b01}) begin
            $display("FAIL conflict_second: got %h want %h", {l2_addr, r0_ready, r1_ready}, {6'h22, 2'b01});
        end else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r1_request = 1'b0; #1;
`ifdef ARB_STATS_EN
        check_cnt++;
        if ({stat_grant0, stat_grant1, stat_conflict} !== {16'd1, 16'd1, 16'd1}) begin
            $display("FAIL conflict_stats: got %h want %h",
                     {stat_grant0, stat_grant1, stat_conflict}, {16'd1, 16'd1, 16'd1});
        end else pass_cnt++;
`endif
    endtask

    task automatic test_alternation();
        r0_request = 1'b1; r1_request = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); l2_ready = 1'b1; #1;
            check_cnt++;
            if ({l2_addr, r1_ready, r0_ready} !== ((t % 2) ? {6'h22, 2'b10} : {6'h11, 2'b01})) begin
                $display("FAIL alt_grant%0d: got %h want %h", t, {l2_addr, r1_ready, r0_ready},
                         ((t % 2) ? {6'h22, 2'b10} : {6'h11, 2'b01}));
            end else pass_cnt++;
            @(negedge clk); l2_ready = 1'b0;
            if (t == 3) begin r0_request = 1'b0; r1_request = 1'b0; end
            #1;
            check_cnt++;
            if (l2_request !== 1'b0) $display("FAIL alt_idle%0d: got %b want 0", t, l2_request);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back_writeback();
        r0_we = 1'b0; r0_addr = 6'h3f; r0_din = 32'haaaa5555; r0_request = 1'b0;
        r1_we = 1'b1; r1_addr = 6'h20; r1_din = 32'h838281ff; r1_request = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 2) r0_request = 1'b1;
            l2_ready = (i == 4);
            #1;
            check_cnt++;
            if ({l2_request, l2_we, l2_addr, l2_din, r0_ready, r1_ready} !==
                {1'b1, 1'b1, 6'h20, 32'h838281ff, 1'b0, (i == 4)}) begin
                $display("FAIL wb_pass_c%0d: got %h want %h", i,
                         {l2_request, l2_we, l2_addr, l2_din, r0_ready, r1_ready},
                         {1'b1, 1'b1, 6'h20, 32'h838281ff, 1'b0, (i == 4)});
            end else pass_cnt++;
        end
        @(negedge clk); l2_ready = 1'b0; r1_request = 1'b0; r1_we = 1'b0; #1;
        check_cnt++;
        if (l2_request !== 1'b0) $display("FAIL wb_idle: got %b want 0", l2_request);
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_we, l2_addr, l2_din, r0_ready} !== {1'b0, 6'h3f, 32'haaaa5555, 1'b1}) begin
            $display("FAIL wb_next_r0: got %h want %h", {l2_we, l2_addr, l2_din, r0_ready},
                     {1'b0, 6'h3f, 32'haaaa5555, 1'b1});
        end else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r0_request = 1'b0;
    endtask

    task automatic test_spurious_ready();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); l2_ready = 1'b1; #1;
            check_cnt++;
            if ({l2_request, r0_ready, r1_ready} !== 3'b000) begin
                $display("FAIL spur_idle%0d: got %b want 000", i, {l2_request, r0_ready, r1_ready});
            end else pass_cnt++;
        end
        @(negedge clk); l2_ready = 1'b0; r1_request = 1'b1; r1_addr = 6'h05; #1;
        check_cnt++;
        if (l2_request !== 1'b0) $display("FAIL spur_arb: got %b want 0", l2_request);
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_request, l2_addr, r1_ready} !== {1'b1, 6'h05, 1'b1}) begin
            $display("FAIL spur_then_grant: got %h want %h", {l2_request, l2_addr, r1_ready}, {1'b1, 6'h05, 1'b1});
        end else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; r1_request = 1'b0;
        // l2_ready in the arbitration cycle itself must not be forwarded.
        @(negedge clk); r0_request = 1'b1; l2_ready = 1'b1; #1;
        check_cnt++;
        if ({l2_request, r0_ready} !== 2'b00) $display("FAIL spur_arb_r0: got %b want 00", {l2_request, r0_ready});
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b0; #1;
        check_cnt++;
        if ({l2_request, r0_ready} !== 2'b10) $display("FAIL spur_grant_r0: got %b want 10", {l2_request, r0_ready});
        else pass_cnt++;
        @(negedge clk); l2_ready = 1'b1;
        @(negedge clk); l2_ready = 1'b0; r0_request = 1'b0;
    endtask

    // Randomized run. The model tracks only who owns the L2 port, who is
    // preferred next, and how long the L2 takes for the current transaction.
    task automatic test_random();
        bit          req [2];
        bit          we_m [2];
        logic [5:0]  addr_m [2];
        logic [31:0] din_m [2];
        bit          rdy [2];
        int          owner = -1, pref = 0, lat = 0, nxt, txn = 0, errs = 0;
        int          gcnt [2];
        int          ccnt = 0;
        logic [105:0] obs, expv;
        gcnt[0] = 0; gcnt[1] = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we_m[i] = 1'b0; addr_m[i] = '0; din_m[i] = '0;
        end
        r0_request = 1'b0; r1_request = 1'b0; l2_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            r0_request = req[0]; r0_we = we_m[0]; r0_addr = addr_m[0]; r0_din = din_m[0];
            r1_request = req[1]; r1_we = we_m[1]; r1_addr = addr_m[1]; r1_din = din_m[1];
            l2_dout  = $urandom;
            l2_ready = (owner >= 0) ? (lat == 0) : ($urandom_range(0, 3) == 0);
            #1;
            obs = {l2_request, l2_we, l2_addr, l2_din, r0_ready, r1_ready, r0_dout, r1_dout};
            if (owner >= 0) expv = {req[owner], we_m[owner], addr_m[owner], din_m[owner],
                                    (owner == 0) && l2_ready, (owner == 1) && l2_ready, l2_dout, l2_dout};
            else            expv = {1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, l2_dout, l2_dout};
            check_cnt++;
            if (obs !== expv) begin
                errs++;
                if (errs <= 5) $display("FAIL random_c%0d: got %h want %h", c, obs, expv);
            end else pass_cnt++;
            rdy[0] = (owner == 0) && l2_ready;
            rdy[1] = (owner == 1) && l2_ready;
            if (owner < 0) begin
                nxt = -1;
                if (req[0] && req[1]) begin ccnt++; nxt = pref; end
                else if (req[0]) nxt = 0;
                else if (req[1]) nxt = 1;
                if (nxt >= 0) begin
                    gcnt[nxt]++;
                    lat = $urandom_range(0, 4);
                    txn++;
                    $display("txn %0d: r%0d we=%0b addr=%h din=%h l2_lat=%0d",
                             txn, nxt, we_m[nxt], addr_m[nxt], din_m[nxt], lat + 1);
                end
                owner = nxt;
            end else if (l2_ready) begin
                pref  = 1 - owner;
                owner = -1;
            end else begin
                lat--;
            end
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] || (!req[i] && ($urandom_range(0, 2) == 0))) begin
                    req[i]    = rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                    we_m[i]   = 1'($urandom);
                    addr_m[i] = 6'($urandom);
                    din_m[i]  = $urandom;
                end
            end
        end
`ifdef ARB_STATS_EN
        check_cnt++;
        if ({stat_grant0, stat_grant1, stat_conflict} !== {16'(gcnt[0]), 16'(gcnt[1]), 16'(ccnt)}) begin
            $display("FAIL random_stats: got %h want %h", {stat_grant0, stat_grant1, stat_conflict},
                     {16'(gcnt[0]), 16'(gcnt[1]), 16'(ccnt)});
        end else pass_cnt++;
`endif
        check_cnt++;
        if (gcnt[0] + gcnt[1] < 20) $display("FAIL random_activity: got %0d want >=20", gcnt[0] + gcnt[1]);
        else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        r0_request = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_din = '0;
        r1_request = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_din = '0;
        l2_ready   = 1'b0; l2_dout = '0;
        test_reset();
        test_single_fill();
        test_conflict();
        test_alternation();
        test_back_to_back_writeback();
        test_spurious_ready();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
